// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader
// Streams the contents of a register file out over a valid/ready channel,
// one register per cycle, by walking a spare combinational read port.
// The block only reads the register file; it never writes it.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   start      begin a dump (only honoured while idle)
//   rf_addr    read address to the register file read port (registered)
//   rf_data    combinational read data for rf_addr
//   out_data   captured register value
//   out_index  address out_data was read from
//   out_last   final word of the dump
//   out_valid  word available
//   out_ready  consumer accepts the word when out_valid & out_ready
//   busy       dump in progress
//   done       one-cycle pulse after the last word is accepted
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start, no word presented
// LOAD   | capture the first word from the read port
// SEND   | word presented; each handshake captures the next word
// DONE   | last word accepted, done pulse for one cycle

module regfile_dump_reader #(
  parameter int W         = 32,
  parameter int L         = 5,
  parameter int SKIP_ZERO = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic [L-1:0] rf_addr,
  input  logic [W-1:0] rf_data,
  output logic [W-1:0] out_data,
  output logic [L-1:0] out_index,
  output logic         out_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic         done
);

  // Register 0 is hard-wired zero on MIPS, so it can optionally be skipped.
  localparam logic [L-1:0] FIRST_ADDR = (SKIP_ZERO != 0) ? L'(1) : '0;
  localparam logic [L-1:0] LAST_ADDR  = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_DONE
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic         capture;
  logic         ptr_init;
  logic [L-1:0] ptr;

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    ptr_init  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          ptr_init  = 1'b1;
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        capture   = 1'b1;
        state_nxt = S_SEND;
      end
      S_SEND: begin
        // Only a handshake moves the stream forward; without one every
        // output and the pointer hold.
        if (out_ready) begin
          if (out_last) state_nxt = S_DONE;
          else          capture   = 1'b1;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      ptr       <= '0;
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (ptr_init) begin
        ptr <= FIRST_ADDR;
      end else if (capture) begin
        out_data  <= rf_data;
        out_index <= ptr;
        out_last  <= (ptr == LAST_ADDR);
        // Wraps to 0 after the last capture; that value is never used.
        ptr       <= ptr + L'(1);
      end
    end
  end

  // A word is presented exactly while in SEND, so valid falls only on the
  // handshake of the last word.
  assign out_valid = (state == S_SEND);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign rf_addr   = ptr;

endmodule

// File: doc/regfile_dump_reader.md
# regfile_dump_reader

Sequential read-out engine for the MIPS general-purpose register file. On a start pulse it walks the register file's combinational read port, one register per cycle, and streams the 32 values over a valid/ready output with index and last tags. It sits beside the register file on a spare read port (debug/state extraction, end-of-run output collection) and never writes it.

## Interface
Parameters:
- W, 32, data width of one register
- L, 5, address width; N = 2**L registers
- SKIP_ZERO, 0, 1 = start at address 1 and emit N-1 words (register 0 is hard-wired zero)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- start  input  1  begin a dump; sampled only in IDLE
- rf_addr  output  L  read address to register file read port
- rf_data  input  W  combinational read data for rf_addr (same cycle)
- out_data  output  W  captured register value
- out_index  output  L  address out_data was read from
- out_last  output  1  marks final word of the dump
- out_valid  output  1  word available
- out_ready  input  1  consumer accepts word when out_valid & out_ready
- busy  output  1  dump in progress
- done  output  1  one-cycle pulse after the last word is accepted

## Operation
- Internal L-bit pointer ptr drives rf_addr directly (registered, no combinational path from inputs).
- States: IDLE, LOAD, SEND, DONE. busy = (state != IDLE); done = (state == DONE).
- IDLE: out_valid=0. start=1 -> ptr <= (SKIP_ZERO ? 1 : 0), go LOAD. start=0 -> stay.
- LOAD: out_data <= rf_data, out_index <= ptr, out_last <= (ptr == N-1), out_valid <= 1, ptr <= ptr+1, go SEND.
- SEND, out_valid=1:
  - out_ready=0: hold out_data/out_index/out_last/ptr stable.
  - out_ready=1 & !out_last: capture next word exactly as in LOAD; stay SEND (valid stays 1).
  - out_ready=1 & out_last: out_valid <= 0, go DONE.
- DONE: go IDLE unconditionally.
- start while busy: ignored, no effect, not queued.
- ptr wraps N-1 -> 0 after the last capture; value unused and harmless.
- Values are read live: a register-file write to an address not yet captured is reflected in the dump; an already-captured word is never updated.
- Word count per dump: N (SKIP_ZERO=0) or N-1 (SKIP_ZERO=1); indices strictly increasing, out_last only on index N-1.

## Timing
- Reset (rst=1 at an edge): state=IDLE, ptr=0, rf_addr=0, out_data=0, out_index=0, out_last=0, out_valid=0, busy=0, done=0. Overrides everything; rst mid-dump aborts immediately, no done pulse, partial stream discarded.
- start sampled at edge T -> LOAD during cycle T+1, out_valid=1 from T+2.
- Throughput 1 word/cycle while out_ready=1; one extra cycle only at start (LOAD).
- With out_ready held high, SKIP_ZERO=0: words accepted in cycles T+2..T+N+1, done=1 in cycle T+N+2, busy high T+1..T+N+2, new start accepted at edge ending cycle T+N+3.
- out_ready low for k cycles inserts exactly k stall cycles; no words dropped or duplicated.
- out_valid never drops without a handshake.

## Test plan
- Basic dump: preload reg[i]=0x1000_0000+i (reg0=0), out_ready=1, pulse start -> 32 words, index 0..31, data matches, out_last only on index 31, done one cycle at T+34, busy deasserts same edge as done.
- Backpressure: random out_ready (about 50%) -> same 32-word sequence, outputs stable whenever valid & !ready, total cycles = 34 + stall count.
- SKIP_ZERO=1: same preload -> 31 words, first index 1 data 0x1000_0001, last index 31, done one cycle after final handshake.
- Start while busy: pulse start again at word 10 -> no restart, sequence continues to 31, exactly one done.
- Reset mid-dump: rst at word 5 with out_ready=0 -> next cycle out_valid=0, busy=0, rf_addr=0, no done; fresh start yields full dump from index 0.
- Live write: write reg[20]=0xDEADBEEF while dump at index 10 and reg[3]=0xCAFEF00D at same time -> index 20 shows 0xDEADBEEF, index 3 shows old value.
